vc_circ_fifo: RTL and testbench

Multi-virtual-channel circular FIFO for NoC router input ports: VC_NUM independent circular queues share one write port and one read port. Each queue holds DATA_W-bit flits. Unlike the single-queue buffer, every queue uses all 2**FIFO_DEPTH_W entries through extended (wrap-bit) pointers and reports per-VC occupancy. Per-VC occupancy feeds the router's credit/arbitration logic.

---
 rtl/vc_circ_fifo.sv | 115 +++++++++++
 tb/tb_vc_circ_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_circ_fifo.sv
// rtl/vc_circ_fifo.sv - multi-VC circular flit FIFO with wrap-bit pointers and per-VC occupancy
// Optional first-word fall-through read path: define VC_FIFO_FWFT_EN.
module vc_circ_fifo #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH_W = 2,
    parameter int VC_NUM       = 2,
    parameter int VC_W         = 1,
    parameter int ID           = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             wr_en_i,
    input  logic [VC_W-1:0]                  wr_vc_i,
    input  logic [DATA_W-1:0]                data_i,
    input  logic                             rd_en_i,
    input  logic [VC_W-1:0]                  rd_vc_i,
    output logic [DATA_W-1:0]                data_o,
    output logic                             valid_o,
    output logic [VC_NUM-1:0]                full_o,
    output logic [VC_NUM-1:0]                empty_o,
    output logic [VC_NUM*(FIFO_DEPTH_W+1)-1:0] count_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam int PW    = FIFO_DEPTH_W + 1;
    localparam int DEPTH = 2 ** FIFO_DEPTH_W;
    localparam logic [VC_W:0] VC_LIM = VC_NUM[VC_W:0];

    // ID only tags the instance for debug; it has no effect on hardware.
    if (ID < 0) begin : g_neg_id
    end

    logic [PW-1:0]     wr_ptr [VC_NUM];
    logic [PW-1:0]     rd_ptr [VC_NUM];
    logic [DATA_W-1:0] mem    [VC_NUM][DEPTH];

    logic [VC_NUM-1:0] full_v;
    logic [VC_NUM-1:0] empty_v;
    logic              wr_sel_ok;
    logic              rd_sel_ok;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] head;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc_status
        assign empty_v[v] = (wr_ptr[v] == rd_ptr[v]);
        assign full_v[v]  = (wr_ptr[v][PW-2:0] == rd_ptr[v][PW-2:0]) &&
                            (wr_ptr[v][PW-1] != rd_ptr[v][PW-1]);
        assign count_o[v*PW +: PW] = wr_ptr[v] - rd_ptr[v];
    end

    assign full_o  = full_v;
    assign empty_o = empty_v;

    assign wr_sel_ok = ({1'b0, wr_vc_i} < VC_LIM);
    assign rd_sel_ok = ({1'b0, rd_vc_i} < VC_LIM);
    assign head      = mem[rd_vc_i][rd_ptr[rd_vc_i][PW-2:0]];

    // A full VC still takes a write when the same VC is popped this cycle.
    always_comb begin
        rd_ok = 1'b0;
        wr_ok = 1'b0;
        if (rd_en_i && rd_sel_ok)
            rd_ok = !empty_v[rd_vc_i];
        if (wr_en_i && wr_sel_ok)
            wr_ok = !full_v[wr_vc_i] || (rd_ok && (rd_vc_i == wr_vc_i));
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok)
            mem[wr_vc_i][wr_ptr[wr_vc_i][PW-2:0]] <= data_i;
    end

`ifdef VC_FIFO_FWFT_EN
    assign data_o  = head;
    assign valid_o = rd_sel_ok && !empty_v[rd_vc_i];
`else
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok)
                data_q <= head;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int v = 0; v < VC_NUM; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr[wr_vc_i] <= wr_ptr[wr_vc_i] + PW'(1);
            if (rd_ok)
                rd_ptr[rd_vc_i] <= rd_ptr[rd_vc_i] + PW'(1);
            overflow_o  <= wr_en_i && !wr_ok;
            underflow_o <= rd_en_i && !rd_ok;
        end
    end

endmodule

// File: tb/tb_vc_circ_fifo.sv
// tb/tb_vc_circ_fifo.sv - self-checking bench for vc_circ_fifo against a queue-based model
module tb_vc_circ_fifo;

    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       wr_en_i;
    logic [0:0] wr_vc_i;
    logic [7:0] data_i;
    logic       rd_en_i;
    logic [0:0] rd_vc_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic [1:0] full_o;
    logic [1:0] empty_o;
    logic [5:0] count_o;
    logic       overflow_o;
    logic       underflow_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovf;
    logic       exp_unf;

    always #5 clk_i = ~clk_i;

    vc_circ_fifo #(
        .DATA_W(8), .FIFO_DEPTH_W(2), .VC_NUM(2), .VC_W(1), .ID(0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_en_i(wr_en_i), .wr_vc_i(wr_vc_i), .data_i(data_i),
        .rd_en_i(rd_en_i), .rd_vc_i(rd_vc_i),
        .data_o(data_o), .valid_o(valid_o),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    function automatic int qsize(input int v);
        return (v == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [5:0] exp_count();
        return {3'(q1.size()), 3'(q0.size())};
    endfunction

    function automatic logic [1:0] exp_empty();
        return {q1.size() == 0, q0.size() == 0};
    endfunction

    function automatic logic [1:0] exp_full();
        return {q1.size() == DEPTH, q0.size() == DEPTH};
    endfunction

    // One clock of stimulus; the model applies the queue rules after the edge.
    task automatic drive(input logic we, input int wvc, input logic [7:0] wd,
                         input logic re, input int rvc);
        bit rd_acc, wr_acc;
        wr_en_i = we; wr_vc_i = 1'(wvc); data_i = wd;
        rd_en_i = re; rd_vc_i = 1'(rvc);
        rd_acc = re && (qsize(rvc) > 0);
        wr_acc = we && ((qsize(wvc) < DEPTH) || (rd_acc && rvc == wvc));
        @(posedge clk_i);
        #1;
        if (rd_acc) begin
            exp_data  = (rvc == 0) ? q0.pop_front() : q1.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (wr_acc) begin
            if (wvc == 0) q0.push_back(wd); else q1.push_back(wd);
        end
        exp_ovf = we && !wr_acc;
        exp_unf = re && !rd_acc;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; wr_en_i = 0; rd_en_i = 0; wr_vc_i = 0; rd_vc_i = 0; data_i = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        exp_data = 0; exp_valid = 0; exp_ovf = 0; exp_unf = 0;
        drive(1, 0, 8'hA1, 0, 0);
        drive(1, 0, 8'hA2, 0, 0);
        drive(0, 0, 8'h00, 1, 0);
        n_checks++;
        if (data_o !== 8'hA1 || valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_read: data_o=%h valid_o=%b expected %h 1", data_o, valid_o, 8'hA1);
        end
        drive(0, 0, 8'h00, 1, 1);
        n_checks++;
        if (underflow_o !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_underflow: got %b expected 1", underflow_o);
        end
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        q0.delete(); q1.delete();
        exp_data = 0; exp_valid = 0; exp_ovf = 0; exp_unf = 0;
        n_checks++;
        if (data_o !== 8'h00 || valid_o !== 1'b0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: data_o=%h valid_o=%b ovf=%b unf=%b expected 00 0 0 0",
                     data_o, valid_o, overflow_o, underflow_o);
        end
        n_checks++;
        if (empty_o !== 2'b11 || full_o !== 2'b00 || count_o !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_status: empty=%b full=%b count=%h expected 11 00 00",
                     empty_o, full_o, count_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, 8'(i), 0, 0);
            n_checks++;
            if (count_o[2:0] !== 3'(i) || overflow_o !== 1'b0) begin
                n_errors++;
                $display("FAIL fill_count: got count=%0d ovf=%b expected %0d 0", count_o[2:0], overflow_o, i);
            end
        end
        n_checks++;
        if (full_o !== exp_full() || empty_o !== exp_empty() || full_o[0] !== 1'b1 || empty_o[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_status: full=%b empty=%b expected %b %b", full_o, empty_o, exp_full(), exp_empty());
        end
        drive(1, 0, 8'hAA, 0, 0);
        n_checks++;
        if (overflow_o !== 1'b1 || count_o[2:0] !== 3'd4) begin
            n_errors++;
            $display("FAIL overflow_pulse: ovf=%b count=%0d expected 1 4", overflow_o, count_o[2:0]);
        end
        drive(0, 0, 8'h00, 0, 0);
        n_checks++;
        if (overflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_clear: got %b expected 0", overflow_o);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 0, 8'h00, 1, 0);
            n_checks++;
            if (data_o !== 8'(i) || data_o !== exp_data || valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_data: data_o=%h valid_o=%b expected %h 1", data_o, valid_o, 8'(i));
            end
        end
        drive(0, 0, 8'h00, 1, 0);
        n_checks++;
        if (underflow_o !== 1'b1 || valid_o !== 1'b0 || empty_o[0] !== 1'b1 || data_o !== exp_data) begin
            n_errors++;
            $display("FAIL underflow_pulse: unf=%b valid=%b empty=%b data=%h expected 1 0 1 %h",
                     underflow_o, valid_o, empty_o[0], data_o, exp_data);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++)
            drive(1, 0, 8'($urandom), 0, 0);
        drive(1, 0, 8'h55, 1, 0);
        n_checks++;
        if (data_o !== exp_data || valid_o !== 1'b1 || overflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL full_rw_read: data=%h valid=%b ovf=%b expected %h 1 0", data_o, valid_o, overflow_o, exp_data);
        end
        n_checks++;
        if (count_o[2:0] !== 3'd4 || full_o[0] !== 1'b1 || q0[DEPTH-1] !== 8'h55) begin
            n_errors++;
            $display("FAIL full_rw_count: count=%0d full=%b expected 4 1", count_o[2:0], full_o[0]);
        end
    endtask

    task automatic test_interleave_wrap();
        drive(1, 1, 8'h10, 1, 0);
        n_checks++;
        if (data_o !== exp_data || valid_o !== 1'b1 || count_o !== exp_count()) begin
            n_errors++;
            $display("FAIL cross_vc: data=%h valid=%b count=%h expected %h 1 %h", data_o, valid_o, count_o, exp_data, exp_count());
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 8'($urandom), 1, 1);
            n_checks++;
            if (data_o !== exp_data || valid_o !== exp_valid || count_o !== exp_count() ||
                overflow_o !== exp_ovf || underflow_o !== exp_unf) begin
                n_errors++;
                $display("FAIL wrap_vc1: data=%h valid=%b count=%h ovf=%b unf=%b expected %h %b %h %b %b",
                         data_o, valid_o, count_o, overflow_o, underflow_o,
                         exp_data, exp_valid, exp_count(), exp_ovf, exp_unf);
            end
        end
    endtask

    task automatic test_empty_same_vc();
        while (q1.size() > 0) drive(0, 0, 8'h00, 1, 1);
        drive(1, 1, 8'h77, 1, 1);
        n_checks++;
        if (underflow_o !== 1'b1 || valid_o !== 1'b0 || count_o[5:3] !== 3'd1) begin
            n_errors++;
            $display("FAIL empty_wr_rd: unf=%b valid=%b count1=%0d expected 1 0 1", underflow_o, valid_o, count_o[5:3]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 6), $urandom_range(0, 1), 8'($urandom),
                  ($urandom_range(0, 9) < 5), $urandom_range(0, 1));
            n_checks++;
            if (data_o !== exp_data || valid_o !== exp_valid || count_o !== exp_count() ||
                full_o !== exp_full() || empty_o !== exp_empty() ||
                overflow_o !== exp_ovf || underflow_o !== exp_unf) begin
                n_errors++;
                $display("FAIL random[%0d]: data=%h valid=%b count=%h full=%b empty=%b ovf=%b unf=%b expected %h %b %h %b %b %b %b",
                         i, data_o, valid_o, count_o, full_o, empty_o, overflow_o, underflow_o,
                         exp_data, exp_valid, exp_count(), exp_full(), exp_empty(), exp_ovf, exp_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rw();
        test_interleave_wrap();
        test_empty_same_vc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
